pos_read_sequencer: RTL and testbench

Sequencer that drives the address and control side of the position pipeline for one PE. On a start pulse it fetches particle counts, then walks every home reference particle through phase 0 and phase 1, sweeping neighbor particle addresses. It stalls on filter back-pressure and signals completion after the pipeline drains. It sits between the PE top-level control and the position caches/pos_data_preprocessor, and generates `phase`, `ref_id`, `particle_id`, `reading_particle_num` and `pause_reading`.

---
 rtl/pos_read_sequencer_if.sv | 31 +++
 rtl/pos_read_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pos_read_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pos_read_sequencer_if.sv
// Position-pipeline read bus between the sequencer and the caches/preprocessor.
//
// Handshake: there is no ready. rd_valid=1 means particle_id/ref_id/phase name
// a neighbour read issued this cycle. Back-pressure flows the other way on
// filter_almost_full and takes effect two cycles later as pause_reading=1, with
// rd_valid=0 and the address held. reading_particle_num=1 marks the count-word
// read, which uses particle_id=0.
interface pos_read_sequencer_if #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NUM_FILTER        = 7
);
  logic [PARTICLE_ID_WIDTH-1:0] home_particle_num;
  logic [PARTICLE_ID_WIDTH-1:0] nb_particle_num_max;
  logic [NUM_FILTER-1:0]        filter_almost_full;
  logic                         phase;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id;
  logic [PARTICLE_ID_WIDTH-1:0] particle_id;
  logic                         reading_particle_num;
  logic                         pause_reading;
  logic                         rd_valid;

  modport master (
    input  home_particle_num, nb_particle_num_max, filter_almost_full,
    output phase, ref_id, particle_id, reading_particle_num, pause_reading, rd_valid
  );

  modport slave (
    output home_particle_num, nb_particle_num_max, filter_almost_full,
    input  phase, ref_id, particle_id, reading_particle_num, pause_reading, rd_valid
  );
endinterface

// File: rtl/pos_read_sequencer.sv
// Address/control sequencer for one PE's position pipeline: reads the particle
// counts, then sweeps every home reference particle through phase 0 and 1
// against all neighbour addresses, pausing on filter back-pressure.
// All outputs come straight from flops; the combinational process computes
// the values they will hold in the next cycle.
module pos_read_sequencer #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NUM_FILTER        = 7,
  parameter int COUNT_LATENCY     = 2,
  parameter int DRAIN_CYCLES      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  pos_read_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           fsm_state
);
  localparam int PW      = PARTICLE_ID_WIDTH;
  localparam int MAX_CNT = (COUNT_LATENCY > DRAIN_CYCLES) ? COUNT_LATENCY : DRAIN_CYCLES;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(COUNT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ_NUM = 3'd1,
    WAIT_NUM = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    home_q, home_d;
  logic [PW-1:0]    nb_q, nb_d;
  logic             phase_q, phase_d;
  logic [PW-1:0]    ref_q, ref_d;
  logic [PW-1:0]    pid_q, pid_d;
  logic             rpn_q, rpn_d;
  logic             pause_q, pause_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stall_q;
  logic [NUM_FILTER-1:0] faf;

  assign faf                      = bus.filter_almost_full;
  assign bus.phase                = phase_q;
  assign bus.ref_id               = ref_q;
  assign bus.particle_id          = pid_q;
  assign bus.reading_particle_num = rpn_q;
  assign bus.pause_reading        = pause_q;
  assign bus.rd_valid             = valid_q;
  assign busy                     = busy_q;
  assign done                     = done_q;
  assign fsm_state                = state_q;

  // State, counters, latched counts, registered back-pressure and all outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      home_q  <= '0;
      nb_q    <= '0;
      phase_q <= 1'b0;
      ref_q   <= '0;
      pid_q   <= '0;
      rpn_q   <= 1'b0;
      pause_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      home_q  <= home_d;
      nb_q    <= nb_d;
      phase_q <= phase_d;
      ref_q   <= ref_d;
      pid_q   <= pid_d;
      rpn_q   <= rpn_d;
      pause_q <= pause_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stall_q <= |faf;
    end
  end

  // Next state and next output values; the address advances only after a
  // cycle in which it was actually issued, so a pause never skips an address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    home_d  = home_q;
    nb_d    = nb_q;
    phase_d = phase_q;
    ref_d   = ref_q;
    pid_d   = pid_q;
    valid_d = 1'b0;
    pause_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ_NUM;
          phase_d = 1'b0;
          ref_d   = '0;
          pid_d   = '0;
        end
      end
      READ_NUM: begin
        state_d = WAIT_NUM;
        cnt_d   = '0;
      end
      WAIT_NUM: begin
        if (cnt_q == WAIT_LAST) begin
          home_d = bus.home_particle_num;
          nb_d   = bus.nb_particle_num_max;
          if (bus.home_particle_num == '0 || bus.nb_particle_num_max == '0) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
            phase_d = 1'b0;
            ref_d   = PW'(1);
            pid_d   = PW'(1);
            valid_d = ~stall_q;
            pause_d = stall_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        valid_d = ~stall_q;
        pause_d = stall_q;
        if (valid_q) begin
          if (pid_q != nb_q) begin
            pid_d = pid_q + 1'b1;
          end else if (!phase_q) begin
            phase_d = 1'b1;
            pid_d   = PW'(1);
          end else if (ref_q != home_q) begin
            ref_d   = ref_q + 1'b1;
            phase_d = 1'b0;
            pid_d   = PW'(1);
          end else begin
            state_d = DRAIN;
            cnt_d   = '0;
            valid_d = 1'b0;
            pause_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rpn_d  = (state_d == READ_NUM);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end
endmodule

// File: tb/tb_pos_read_sequencer.sv
// Bench for pos_read_sequencer: a nested-loop model pushes the expected
// (ref_id, phase, particle_id) issue order, and a negedge monitor pops and
// compares on every rd_valid while recording timing of the pass.
module tb_pos_read_sequencer;
  localparam int PW = 7;
  localparam int NF = 7;
  localparam int CL = 2;
  localparam int DC = 4;
  localparam int W  = 2 * PW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [2:0] fsm_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pos_read_sequencer_if #(.PARTICLE_ID_WIDTH(PW), .NUM_FILTER(NF)) bus ();

  pos_read_sequencer #(
    .PARTICLE_ID_WIDTH(PW), .NUM_FILTER(NF),
    .COUNT_LATENCY(CL), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int start_cyc, n_valid, first_valid_cyc, last_valid_cyc;
  int n_done, done_cyc, n_pause, first_pause_cyc, rpn_cyc;
  int max_ref, max_pid;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] cur_word();
    return {bus.ref_id, bus.phase, bus.particle_id};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.rd_valid) begin
      if (n_valid == 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
      n_valid++;
      if (int'(bus.ref_id) > max_ref) max_ref = int'(bus.ref_id);
      if (int'(bus.particle_id) > max_pid) max_pid = int'(bus.particle_id);
      check_eq("valid_xor_pause", int'(bus.pause_reading), 0);
      check_eq("issue_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("issue_addr", int'(cur_word()), int'(e));
      end
    end
    if (bus.pause_reading) begin
      if (n_pause == 0) first_pause_cyc = cyc;
      n_pause++;
      if (exp_q.size() > 0) check_eq("held_addr", int'(cur_word()), int'(exp_q[0]));
    end
    if (bus.reading_particle_num) begin
      rpn_cyc = cyc;
      check_eq("count_read_addr", int'(cur_word()), 0);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    n_valid = 0; first_valid_cyc = -1; last_valid_cyc = -1;
    n_done = 0; done_cyc = -1; n_pause = 0; first_pause_cyc = -1; rpn_cyc = -1;
    max_ref = 0; max_pid = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic launch(input int h, input int n);
    clear_stats();
    for (int r = 1; r <= h; r++)
      for (int p = 0; p < 2; p++)
        for (int i = 1; i <= n; i++)
          exp_q.push_back({PW'(r), 1'(p), PW'(i)});
    bus.home_particle_num   = PW'(h);
    bus.nb_particle_num_max = PW'(n);
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      step();
      k++;
    end
    check_eq("done_seen", int'(n_done > 0), 1);
  endtask

  task automatic check_pass(input string name, input int exp_valid);
    step();
    check_eq({name, "_valid_count"}, n_valid, exp_valid);
    check_eq({name, "_queue_left"}, exp_q.size(), 0);
    check_eq({name, "_count_read_cyc"}, rpn_cyc - start_cyc, 1);
    check_eq({name, "_done_pulses"}, n_done, 1);
    check_eq({name, "_idle_busy"}, int'(busy), 0);
    check_eq({name, "_idle_state"}, int'(fsm_state), 0);
    if (exp_valid > 0) begin
      check_eq({name, "_first_valid"}, first_valid_cyc - start_cyc, CL + 2);
      check_eq({name, "_done_lat"}, done_cyc - last_valid_cyc, DC + 1);
    end else begin
      check_eq({name, "_done_from_start"}, done_cyc - start_cyc, CL + 2);
    end
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, "_phase"}, int'(bus.phase), 0);
    check_eq({name, "_ref_id"}, int'(bus.ref_id), 0);
    check_eq({name, "_particle_id"}, int'(bus.particle_id), 0);
    check_eq({name, "_rpn"}, int'(bus.reading_particle_num), 0);
    check_eq({name, "_pause"}, int'(bus.pause_reading), 0);
    check_eq({name, "_rd_valid"}, int'(bus.rd_valid), 0);
    check_eq({name, "_busy"}, int'(busy), 0);
    check_eq({name, "_done"}, int'(done), 0);
    check_eq({name, "_state"}, int'(fsm_state), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int faf_cyc;
    start = 1'b0;
    rst   = 1'b0;
    bus.home_particle_num   = '0;
    bus.nb_particle_num_max = '0;
    bus.filter_almost_full  = '0;
    clear_stats();
    repeat (3) step();
    check_outputs_zero("reset");
    rst = 1'b1;
    step();

    // basic 2x3 pass, contiguous issue
    launch(2, 3);
    wait_done(200);
    check_eq("basic_contiguous", last_valid_cyc - first_valid_cyc + 1, 12);
    check_pass("basic", 12);

    // 4-cycle back-pressure on filter 3 during the phase-1 sweep of ref 1
    launch(2, 3);
    wait_cyc(start_cyc + 8);
    bus.filter_almost_full = 7'b0001000;
    faf_cyc = cyc;
    repeat (4) step();
    bus.filter_almost_full = '0;
    wait_done(200);
    check_eq("stall_pause_count", n_pause, 4);
    check_eq("stall_pause_lat", first_pause_cyc - faf_cyc, 2);
    check_pass("stall", 12);

    // zero counts end early with no issues
    launch(0, 5);
    wait_done(50);
    check_pass("zero_home", 0);
    launch(4, 0);
    wait_done(50);
    check_pass("zero_nb", 0);

    // random back-pressure on random filters
    launch(3, 5);
    k = 0;
    while (n_done == 0 && k < 2000) begin
      bus.filter_almost_full = ($urandom_range(0, 3) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
      step();
      k++;
    end
    bus.filter_almost_full = '0;
    check_eq("random_done_seen", int'(n_done > 0), 1);
    check_pass("random", 30);

    // start re-pulsed while streaming, count inputs scrambled after latch
    launch(2, 3);
    wait_cyc(start_cyc + 7);
    start = 1'b1;
    bus.home_particle_num   = PW'($urandom_range(1, 127));
    bus.nb_particle_num_max = PW'($urandom_range(1, 127));
    step();
    start = 1'b0;
    wait_done(200);
    check_pass("restart_ignored", 12);

    // full-width pass
    launch(127, 127);
    wait_done(40000);
    check_eq("max_ref_id", max_ref, 127);
    check_eq("max_particle_id", max_pid, 127);
    check_pass("max", 32258);

    // reset while stalled mid-stream, then a clean pass
    launch(2, 3);
    wait_cyc(start_cyc + 6);
    bus.filter_almost_full = 7'b0000001;
    k = 0;
    while (n_pause == 0 && k < 20) begin
      step();
      k++;
    end
    check_eq("rst_stall_seen", int'(n_pause > 0), 1);
    rst = 1'b0;
    step();
    check_outputs_zero("mid_reset");
    rst = 1'b1;
    bus.filter_almost_full = '0;
    exp_q.delete();
    repeat (10) step();
    check_eq("abandoned_no_done", n_done, 0);
    launch(2, 3);
    wait_done(200);
    check_pass("post_reset", 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
